// File: rtl/l8_bram2_writer.sv
// rtl/l8_bram2_writer.sv - packs 16-bit lane values into rows and writes them to the lane memory
module l8_bram2_writer #(
   parameter int N_adder_tree = 16,
   parameter int addr_width   = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [addr_width-1:0]        base_addr,
   input  logic [addr_width:0]          num_rows,
   input  logic [15:0]                  in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [addr_width-1:0]        BRAM2_addr,
   output logic [N_adder_tree*16-1:0]   BRAM2_in,
   output logic                         wr,
   output logic                         busy,
   output logic                         done
);

   localparam int LW = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   state_t                      r_state;
   state_t                      w_next_state;
   logic [addr_width-1:0]       r_base;
   logic [addr_width:0]         r_num;
   logic [addr_width:0]         r_row;
   logic [LW-1:0]               r_lane;
   logic                        r_in_ready;
   logic                        r_wr;
   logic                        r_busy;
   logic                        r_done;
   logic [addr_width-1:0]       r_addr;
   logic [N_adder_tree*16-1:0]  r_data;
   logic                        w_xfer;
   logic                        w_last_lane;
   logic [addr_width:0]         w_row_next;

   // r_in_ready is high exactly while in FILL, so it doubles as the FILL qualifier
   assign w_xfer      = r_in_ready && in_valid;
   assign w_last_lane = (r_lane == LW'(N_adder_tree - 1));
   assign w_row_next  = r_row + 1'b1;

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // next-state decode; start is only honoured in IDLE
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = (num_rows == '0) ? S_FIN : S_FILL;
         S_FILL:  if (w_xfer && w_last_lane) w_next_state = S_WRITE;
         S_WRITE: w_next_state = (w_row_next == r_num) ? S_FIN : S_FILL;
         S_FIN:   w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // job parameters and lane/row counters
   always_ff @(posedge clk) begin
      if (rst) begin
         r_base <= '0;
         r_num  <= '0;
         r_row  <= '0;
         r_lane <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_base <= base_addr;
               r_num  <= num_rows;
               r_row  <= '0;
               r_lane <= '0;
            end
            S_FILL: if (w_xfer) r_lane <= w_last_lane ? '0 : r_lane + 1'b1;
            S_WRITE: begin
               r_row  <= w_row_next;
               r_lane <= '0;
            end
            default: ;
         endcase
      end
   end

   // row packing register; lanes are overwritten in place and never cleared between rows
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
      end else begin
         for (int k = 0; k < N_adder_tree; k++) begin
            if (w_xfer && (r_lane == LW'(k))) r_data[k*16 +: 16] <= in_data;
         end
      end
   end

   // registered outputs, decoded from the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_ready <= 1'b0;
         r_wr       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_addr     <= '0;
      end else begin
         r_in_ready <= (w_next_state == S_FILL);
         r_wr       <= (w_next_state == S_WRITE);
         r_busy     <= (w_next_state != S_IDLE);
         r_done     <= (w_next_state == S_FIN);
         if (w_next_state == S_WRITE && r_state == S_FILL)
            r_addr <= r_base + r_row[addr_width-1:0];
      end
   end

   assign in_ready   = r_in_ready;
   assign wr         = r_wr;
   assign busy       = r_busy;
   assign done       = r_done;
   assign BRAM2_addr = r_addr;
   assign BRAM2_in   = r_data;

endmodule

// File: tb/tb_l8_bram2_writer.sv
// tb/tb_l8_bram2_writer.sv - scoreboard bench for l8_bram2_writer
module tb_l8_bram2_writer;

   localparam int N  = 4;
   localparam int AW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [AW-1:0]   base_addr = '0;
   logic [AW:0]     num_rows = '0;
   logic [15:0]     in_data = '0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [AW-1:0]   BRAM2_addr;
   logic [N*16-1:0] BRAM2_in;
   logic            wr;
   logic            busy;
   logic            done;

   l8_bram2_writer #(.N_adder_tree(N), .addr_width(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .BRAM2_addr(BRAM2_addr), .BRAM2_in(BRAM2_in), .wr(wr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit              is_done;
      logic [AW-1:0]   addr;
      logic [N*16-1:0] data;
      int              gap;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   last_wr_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic push_wr(input logic [AW-1:0] a, input logic [N*16-1:0] d, input int gap);
      exp_t e;
      e.is_done = 1'b0; e.addr = a; e.data = d; e.gap = gap;
      q.push_back(e);
   endtask

   task automatic push_done();
      exp_t e;
      e.is_done = 1'b1; e.addr = '0; e.data = '0; e.gap = 0;
      q.push_back(e);
   endtask

   // monitor: every wr/done the DUT presents is matched against the scoreboard queue
   always @(negedge clk) begin
      if (!rst && wr) begin
         exp_t e;
         check("in_ready_low_in_write", 64'(in_ready), 64'd0);
         if (q.size() == 0 || q[0].is_done) begin
            check("unexpected_wr", 64'd1, 64'd0);
         end else begin
            e = q.pop_front();
            check("wr_addr", 64'(BRAM2_addr), 64'(e.addr));
            check("wr_data", BRAM2_in, e.data);
            if (e.gap != 0) check("wr_spacing", 64'(cyc - last_wr_cyc), 64'(e.gap));
         end
         last_wr_cyc = cyc;
      end
      if (!rst && done) begin
         if (q.size() == 0 || !q[0].is_done) check("unexpected_done", 64'd1, 64'd0);
         else void'(q.pop_front());
      end
   end

   task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; num_rows = n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [15:0] v, input int gaps);
      int bound;
      for (int g = 0; g < gaps; g++) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = v;
      bound = 0;
      while (!in_ready && bound < 100) begin
         @(posedge clk); #1;
         bound++;
      end
      if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int bound;
      bound = 0;
      while (busy && bound < 100) begin
         @(posedge clk); #1;
         bound++;
      end
      if (busy) check("idle_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
   endtask

   logic [15:0] bp_data [8] = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3,
                                16'h00A4, 16'h00A5, 16'h00A6, 16'h00A7};
   int          bp_gaps [8] = '{0, 2, 1, 3, 0, 1, 2, 0};

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_wr", 64'(wr), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_addr", 64'(BRAM2_addr), 64'd0);
      check("rst_data", BRAM2_in, 64'd0);
      rst = 1'b0;

      // basic job, streaming input, rows 5 cycles apart
      push_wr(4'd3, 64'h0004_0003_0002_0001, 0);
      push_wr(4'd4, 64'h0008_0007_0006_0005, 5);
      push_done();
      do_start(4'd3, 5'd2);
      check("busy_in_fill", 64'(busy), 64'd1);
      for (int i = 1; i <= 8; i++) send(16'(i), 0);
      wait_idle();

      // empty job
      push_done();
      do_start(4'd0, 5'd0);
      check("empty_done_next_cycle", 64'(done), 64'd1);
      check("empty_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      check("empty_in_ready_after", 64'(in_ready), 64'd0);
      check("empty_idle_after", 64'(busy), 64'd0);
      wait_idle();

      // address wrap
      push_wr(4'd15, 64'h0014_0013_0012_0011, 0);
      push_wr(4'd0,  64'h0018_0017_0016_0015, 5);
      push_done();
      do_start(4'd15, 5'd2);
      for (int i = 0; i < 8; i++) send(16'h0011 + 16'(i), 0);
      wait_idle();

      // backpressure: in_valid gaps
      push_wr(4'd5, 64'h00A3_00A2_00A1_00A0, 0);
      push_wr(4'd6, 64'h00A7_00A6_00A5_00A4, 0);
      push_done();
      do_start(4'd5, 5'd2);
      for (int i = 0; i < 8; i++) send(bp_data[i], bp_gaps[i]);
      wait_idle();

      // reset mid-job: abandoned row never written, no done
      do_start(4'd7, 5'd2);
      send(16'hDEAD, 0);
      send(16'hBEEF, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_wr", 64'(wr), 64'd0);
      push_wr(4'd0, 64'h0024_0023_0022_0021, 0);
      push_done();
      do_start(4'd0, 5'd1);
      for (int i = 0; i < 4; i++) send(16'h0021 + 16'(i), 0);
      wait_idle();

      // start while busy is ignored
      push_wr(4'd9, 64'h0034_0033_0032_0031, 0);
      push_done();
      do_start(4'd9, 5'd1);
      send(16'h0031, 0);
      send(16'h0032, 0);
      do_start(4'd2, 5'd3);
      send(16'h0033, 0);
      send(16'h0034, 0);
      wait_idle();
      repeat (5) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
